round_sequencer: RTL
====================

# round_sequencer

Top-level game sequencer for the symbol-counter game. It runs a fixed number of rounds. Each round starts the symbol generator, triggers the answer-period block once generation ends, and scores the player's count against the true count. It then holds the result before starting the next round. It sits between the start button, the symbol generator, the answer-period block and the score display.

## Interface
- NUM_ROUNDS, 5, rounds per game (1-15)
- GEN_TIMEOUT, 10, seconds allowed in generation before forced advance
- ANSWER_TIMEOUT, 8, seconds allowed for postSig before forced scoring
- SCORE_HOLD, 3, seconds the round result is held before the next round
- Clk100M  in  1  system clock; all logic on rising edge
- nReset  in  1  asynchronous, active-low reset
- Tick1Hz  in  1  one-cycle pulse once per second, Clk100M domain
- startBtn  in  1  debounced, synchronized start level
- genDone  in  1  one-cycle pulse: generator finished showing symbols
- postSig  in  1  one-cycle pulse: answer period finished
- actualCount  in  8  true symbol count for the current round
- userCount  in  8  player's entered count
- genStart  out  1  one-cycle pulse: start symbol generation
- answerSig  out  1  one-cycle pulse: start answer period
- score  out  8  correct rounds this game, saturating at 255
- round  out  4  current round number; 0 when idle
- lastCorrect  out  1  result of the most recently scored round
- timedOut  out  1  most recent round was scored by the answer watchdog
- gameOver  out  1  high in GAMEOVER
- state  out  3  encoded state: IDLE=0, GENERATE=1, ANSWER=2, SCORE=3, GAMEOVER=4

## Operation
- Reset (async, nReset=0): state=IDLE and all outputs 0. Internal secCount=0. startPrev=1, so a button held through reset does not start a game.
- Start edge: startBtn=1 and startPrev=0 at the same sampling edge. startPrev takes startBtn every cycle.
- IDLE / GAMEOVER, on start edge:
  - score=0, round=1, lastCorrect=0, timedOut=0, secCount=0.
  - genStart pulses; go to GENERATE. gameOver falls on leaving GAMEOVER.
  - Start edges in any other state are ignored.
- GENERATE:
  - On genDone, answerSig pulses, secCount=0, go to ANSWER.
  - Each Tick1Hz increments secCount.
  - If Tick1Hz arrives with secCount==GEN_TIMEOUT-1, the block behaves exactly as on genDone.
  - genDone and timeout in the same cycle: a single transition.
- ANSWER:
  - On postSig, compare userCount==actualCount as sampled in that cycle.
  - If equal: score+1 (held at 255 if already 255) and lastCorrect=1. Otherwise lastCorrect=0.
  - timedOut=0, secCount=0, go to SCORE.
  - Watchdog: if Tick1Hz arrives with secCount==ANSWER_TIMEOUT-1 and no postSig, then lastCorrect=0, timedOut=1, score unchanged, go to SCORE.
  - postSig and watchdog expiry in the same cycle: postSig wins.
  - A genDone arriving in ANSWER is ignored.
- SCORE:
  - Count Tick1Hz. On the Tick1Hz where secCount==SCORE_HOLD-1:
    - If round==NUM_ROUNDS, go to GAMEOVER; round keeps its value.
    - Otherwise round+1, genStart pulses, secCount=0, go to GENERATE.
- GAMEOVER: score, round and lastCorrect hold until the next start edge.
- Stray postSig or genDone outside ANSWER or GENERATE respectively: ignored.

## Timing
- All outputs are registered and change only on Clk100M rising edges, except during async reset.
- Triggering event sampled at edge N: the state change and any pulse are visible after edge N. Pulses last exactly one cycle and are low again after edge N+1.
- Timeouts fire on the Nth Tick1Hz after state entry. The entry-cycle Tick1Hz does not count, because secCount is cleared on entry.
- A game of R rounds with prompt genDone/postSig produces exactly R genStart pulses and R answerSig pulses.
- nReset asserted mid-game forces IDLE immediately. No pulse is emitted on reset release.

## Test plan
- Reset with startBtn held high, release nReset -> state stays IDLE, no genStart. Drop then raise startBtn -> genStart pulse, state=1, round=1.
- Full game, NUM_ROUNDS=5, userCount==actualCount=12 every round -> score=5, round=5, lastCorrect=1, gameOver=1, exactly 5 genStart and 5 answerSig pulses.
- Round with userCount=7, actualCount=9 -> lastCorrect=0, score unchanged. Next round with both 9 -> score+1.
- No genDone for 10 ticks -> answerSig pulses on the 10th tick. Then no postSig for 8 ticks -> timedOut=1, state=SCORE, score unchanged.
- postSig in the same cycle as the 8th ANSWER tick -> scored normally, timedOut=0. Start edge during ANSWER -> ignored.
- nReset pulsed low while state=ANSWER with score=3 -> state=0, score=0, round=0, no pulses.

Source files
------------

// File: rtl/round_sequencer.sv
// round_sequencer: runs a fixed number of generate/answer/score rounds and keeps the game score
module round_sequencer #(
    parameter int NUM_ROUNDS     = 5,
    parameter int GEN_TIMEOUT    = 10,
    parameter int ANSWER_TIMEOUT = 8,
    parameter int SCORE_HOLD     = 3
) (
    input  logic       Clk100M,
    input  logic       nReset,
    input  logic       Tick1Hz,
    input  logic       startBtn,
    input  logic       genDone,
    input  logic       postSig,
    input  logic [7:0] actualCount,
    input  logic [7:0] userCount,
    output logic       genStart,
    output logic       answerSig,
    output logic [7:0] score,
    output logic [3:0] round,
    output logic       lastCorrect,
    output logic       timedOut,
    output logic       gameOver,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GENERATE = 3'd1,
        S_ANSWER   = 3'd2,
        S_SCORE    = 3'd3,
        S_GAMEOVER = 3'd4
    } state_t;

    localparam logic [7:0] GEN_LAST   = 8'(GEN_TIMEOUT - 1);
    localparam logic [7:0] ANS_LAST   = 8'(ANSWER_TIMEOUT - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(SCORE_HOLD - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t     r_state, w_state;
    logic [7:0] r_sec, w_sec;
    logic [7:0] r_score, w_score;
    logic [3:0] r_round, w_round;
    logic       r_start_prev, r_last, w_last, r_timed_out, w_timed_out;
    logic       r_gen_start, w_gen_start, r_answer, w_answer, r_game_over;
    logic       w_start_edge;

    assign w_start_edge = startBtn & ~r_start_prev;

    always_comb begin
        w_state     = r_state;
        w_sec       = r_sec;
        w_score     = r_score;
        w_round     = r_round;
        w_last      = r_last;
        w_timed_out = r_timed_out;
        w_gen_start = 1'b0;
        w_answer    = 1'b0;
        case (r_state)
            S_IDLE, S_GAMEOVER: begin
                if (w_start_edge) begin
                    w_score     = 8'd0;
                    w_round     = 4'd1;
                    w_last      = 1'b0;
                    w_timed_out = 1'b0;
                    w_sec       = 8'd0;
                    w_gen_start = 1'b1;
                    w_state     = S_GENERATE;
                end
            end
            S_GENERATE: begin
                if (genDone || (Tick1Hz && r_sec == GEN_LAST)) begin
                    w_answer = 1'b1;
                    w_sec    = 8'd0;
                    w_state  = S_ANSWER;
                end else if (Tick1Hz) begin
                    w_sec = r_sec + 8'd1;
                end
            end
            S_ANSWER: begin
                if (postSig) begin
                    w_last      = (userCount == actualCount);
                    w_score     = (w_last && r_score != 8'hFF) ? r_score + 8'd1 : r_score;
                    w_timed_out = 1'b0;
                    w_sec       = 8'd0;
                    w_state     = S_SCORE;
                end else if (Tick1Hz && r_sec == ANS_LAST) begin
                    w_last      = 1'b0;
                    w_timed_out = 1'b1;
                    w_sec       = 8'd0;
                    w_state     = S_SCORE;
                end else if (Tick1Hz) begin
                    w_sec = r_sec + 8'd1;
                end
            end
            S_SCORE: begin
                if (Tick1Hz && r_sec == HOLD_LAST) begin
                    w_sec       = 8'd0;
                    w_state     = (r_round == LAST_ROUND) ? S_GAMEOVER : S_GENERATE;
                    w_round     = (r_round == LAST_ROUND) ? r_round : r_round + 4'd1;
                    w_gen_start = (r_round != LAST_ROUND);
                end else if (Tick1Hz) begin
                    w_sec = r_sec + 8'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk100M or negedge nReset) begin
        if (!nReset) begin
            r_state      <= S_IDLE;
            r_sec        <= 8'd0;
            r_score      <= 8'd0;
            r_round      <= 4'd0;
            r_last       <= 1'b0;
            r_timed_out  <= 1'b0;
            r_gen_start  <= 1'b0;
            r_answer     <= 1'b0;
            r_game_over  <= 1'b0;
            r_start_prev <= 1'b1;
        end else begin
            r_state      <= w_state;
            r_sec        <= w_sec;
            r_score      <= w_score;
            r_round      <= w_round;
            r_last       <= w_last;
            r_timed_out  <= w_timed_out;
            r_gen_start  <= w_gen_start;
            r_answer     <= w_answer;
            r_game_over  <= (w_state == S_GAMEOVER);
            r_start_prev <= startBtn;
        end
    end

    assign genStart    = r_gen_start;
    assign answerSig   = r_answer;
    assign score       = r_score;
    assign round       = r_round;
    assign lastCorrect = r_last;
    assign timedOut    = r_timed_out;
    assign gameOver    = r_game_over;
    assign state       = r_state;
endmodule
